gray_code_pipe: RTL and testbench

- Parametrised, pipelined Gray/binary code converter with a valid/ready handshake on both sides.
- Runtime mode selects per beat: Gray to binary (prefix XOR from MSB) or binary to Gray (b ^ (b>>1)).
- Sits between Gray-coded sources (encoders, counter snapshots, CDC pointers) and binary consumers, or the reverse.
- Replaces fixed-width combinational converters.

---
 rtl/gray_code_pipe.sv | 122 ++++++++++++
 tb/tb_gray_code_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_code_pipe.sv
// Two-stage valid/ready Gray <-> binary converter; mode travels with each beat.
// Optional Gray step checking is built only when GRAY_STEP_CHECK_EN is defined.
module gray_code_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             step_err
);

    logic                    r_vld_p1;
    logic signed [WIDTH-1:0] r_data_p1;
    logic                    r_mode_p1;
    logic                    r_vld_p2;
    logic signed [WIDTH-1:0] r_data_p2;
    logic                    r_mode_p2;
    logic                    r_err_p2;

    logic                    w_s2_adv;
    logic                    w_s1_adv;
    logic                    w_in_xfer;
    logic signed [WIDTH-1:0] w_conv_p1;
    logic                    w_err_p1;

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign w_s2_adv  = !r_vld_p2 || out_ready;
    assign w_s1_adv  = r_vld_p1 && w_s2_adv;
    assign in_ready  = !r_vld_p1 || w_s2_adv;
    assign w_in_xfer = in_valid && in_ready;

    // Stage 0 -> 1: capture the raw word and its mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_in_xfer) begin
            r_vld_p1 <= 1'b1;
        end else if (w_s1_adv) begin
            r_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_data_p1 <= in_data;
            r_mode_p1 <= in_mode;
        end
    end

    assign w_conv_p1 = r_mode_p1 ? bin_to_gray(r_data_p1) : gray_to_bin(r_data_p1);

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] r_hist;
    logic             r_hist_vld;

    // More than one set bit means the Gray word moved by more than one step
    function automatic logic multi_bit(input logic [WIDTH-1:0] d);
        return (d & (d - WIDTH'(1))) != '0;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist     <= '0;
            r_hist_vld <= 1'b0;
        end else if (w_s1_adv) begin
            if (!r_mode_p1) begin
                r_hist     <= r_data_p1;
                r_hist_vld <= 1'b1;
            end else begin
                r_hist_vld <= 1'b0;
            end
        end
    end

    assign w_err_p1 = !r_mode_p1 && r_hist_vld && multi_bit(r_hist ^ r_data_p1);
`else
    assign w_err_p1 = 1'b0;
`endif

    // Stage 1 -> 2: output register, cleared by reset so no partial beat escapes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_mode_p2 <= 1'b0;
            r_err_p2  <= 1'b0;
        end else if (w_s2_adv) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2 <= w_conv_p1;
                r_mode_p2 <= r_mode_p1;
                r_err_p2  <= w_err_p1;
            end
        end
    end

    assign out_valid = r_vld_p2;
    assign out_data  = r_data_p2;
    assign out_mode  = r_mode_p2;
    assign step_err  = r_err_p2;

endmodule

// File: tb/tb_gray_code_pipe.sv
// Bench for gray_code_pipe: 8-bit and 4-bit instances share one stream and are
// scored against an arithmetic Gray model; step checking follows GRAY_STEP_CHECK_EN.
module tb_gray_code_pipe;

    localparam int W = 8;
`ifdef GRAY_STEP_CHECK_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_mode;
    logic         step_err;
    logic         in_ready4;
    logic         out_valid4;
    logic [3:0]   out_data4;
    logic         out_mode4;
    logic         step_err4;

    gray_code_pipe #(.WIDTH(W)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .step_err(step_err)
    );

    gray_code_pipe #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data[3:0]), .in_mode(in_mode),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_mode(out_mode4), .step_err(step_err4)
    );

    typedef struct { logic mode; logic [7:0] e8; logic [3:0] e4; logic err; } exp_t;
    typedef struct { logic mode; logic [7:0] d8; logic [3:0] d4; logic err; } cap_t;
    typedef struct { logic mode; logic [7:0] din; logic [7:0] e8; logic [3:0] e4; } vec_t;
    typedef struct { logic mode; logic [7:0] din; logic err; } stp_t;

    exp_t       sb_q[$];
    cap_t       cap_q[$];
    logic [7:0] m_prev;
    logic       m_hv;
    int         n_chk;
    int         n_pass;
    logic       rand_rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gray -> binary as XOR of all right shifts; binary -> Gray as b ^ (b >> 1)
    function automatic logic [7:0] ref_g2b(input logic [7:0] g);
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < 8; k++) b = b ^ (g >> k);
        return b;
    endfunction

    function automatic logic [7:0] ref_b2g(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_chk++;
        $display("FAIL %s: got %0h, want none", name, act);
    endtask

    always @(negedge clk) begin : mon
        cap_t c;
        exp_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                c.mode = out_mode; c.d8 = out_data; c.d4 = out_data4; c.err = step_err;
                cap_q.push_back(c);
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_beat", out_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("data8", out_data, e.e8);
                    chk("data4", out_data4, e.e4);
                    chk("valid4", out_valid4, 1);
                    chk("mode8", out_mode, e.mode);
                    chk("mode4", out_mode4, e.mode);
                    chk("step_err", step_err, e.err);
                end
            end
            if (in_valid && in_ready) begin
                e.mode = in_mode;
                if (in_mode) begin
                    e.e8 = ref_b2g(in_data);
                    e.e4 = 4'(ref_b2g(8'(in_data[3:0])));
                    e.err = 1'b0;
                    m_hv = 1'b0;
                end else begin
                    e.e8 = ref_g2b(in_data);
                    e.e4 = 4'(ref_g2b(8'(in_data[3:0])));
                    e.err = STEP_EN && m_hv && ($countones(m_prev ^ in_data) > 1);
                    m_prev = in_data;
                    m_hv = 1'b1;
                end
                sb_q.push_back(e);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic m, input logic [7:0] d);
        logic acc;
        logic done;
        done = 1'b0;
        in_valid = 1'b1; in_mode = m; in_data = d;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            acc = in_ready;
            step();
            done = acc;
        end
        if (!done) fail_now("accept_timeout", d);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && sb_q.size() != 0; t++) step();
        chk("drain", sb_q.size(), 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        #3;
        sb_q.delete();
        m_hv = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        vec_t tbl[8];
        stp_t stp[6];
        int   base;

        n_chk = 0; n_pass = 0; rand_rdy = 1'b0; m_hv = 1'b0; m_prev = '0;
        in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;

        tbl[0] = '{1'b0, 8'h0B, 8'h0D, 4'hD};
        tbl[1] = '{1'b1, 8'h0D, 8'h0B, 4'hB};
        tbl[2] = '{1'b0, 8'hFF, 8'hAA, 4'hA};
        tbl[3] = '{1'b1, 8'hFF, 8'h80, 4'h8};
        tbl[4] = '{1'b0, 8'h80, 8'hFF, 4'h0};
        tbl[5] = '{1'b1, 8'hAA, 8'hFF, 4'hF};
        tbl[6] = '{1'b0, 8'h55, 8'h66, 4'h6};
        tbl[7] = '{1'b1, 8'h3C, 8'h22, 4'hA};

        stp[0] = '{1'b0, 8'h00, 1'b0};
        stp[1] = '{1'b0, 8'h01, 1'b0};
        stp[2] = '{1'b0, 8'h01, 1'b0};
        stp[3] = '{1'b0, 8'h07, STEP_EN};
        stp[4] = '{1'b1, 8'h05, 1'b0};
        stp[5] = '{1'b0, 8'h0F, 1'b0};

        rst = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_step_err", step_err, 0);
        step();
        rst = 1'b0;
        step();
        chk("rst_in_ready", in_ready, 1);

        // Directed vectors with exact two-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_beat(tbl[i].mode, tbl[i].din);
            chk("lat_early_valid", out_valid, 0);
            step();
            chk("lat_valid", out_valid, 1);
            chk("tbl_data8", out_data, tbl[i].e8);
            chk("tbl_data4", out_data4, tbl[i].e4);
            chk("tbl_mode", out_mode, tbl[i].mode);
            step();
        end

        // Exhaustive 8-bit round trip
        base = cap_q.size();
        for (int i = 0; i < 256; i++) send_beat(1'b1, 8'(i));
        drain();
        for (int i = 0; i < 256; i++) send_beat(1'b0, cap_q[base + i].d8);
        drain();
        chk("rt_count", cap_q.size(), base + 512);
        if (cap_q.size() >= base + 512)
            for (int i = 0; i < 256; i++) chk("roundtrip", cap_q[base + 256 + i].d8, i);

        // Stall: capacity two, then ordered release
        do_reset();
        out_ready = 1'b0;
        base = cap_q.size();
        in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h01;
        step();
        in_data = 8'h02;
        step();
        in_data = 8'h03;
        @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, 8'h01);
        step(); step();
        @(negedge clk);
        chk("stall_hold_ready", in_ready, 0);
        chk("stall_hold_data", out_data, 8'h01);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_ready_comb", in_ready, 1);
        step();
        in_valid = 1'b0;
        drain();
        chk("stall_count", cap_q.size(), base + 3);
        if (cap_q.size() >= base + 3) begin
            chk("stall_o0", cap_q[base].d8, 8'h01);
            chk("stall_o1", cap_q[base + 1].d8, 8'h03);
            chk("stall_o2", cap_q[base + 2].d8, 8'h02);
            chk("stall_o1_w4", cap_q[base + 1].d4, 4'h3);
        end

        // Reset with two beats in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 1'b1; in_data = 8'h5A;
        step();
        in_data = 8'hC3;
        step();
        in_valid = 1'b0;
        chk("inflight_valid", out_valid, 1);
        chk("inflight_data", out_data, 8'h77);
        #3;
        rst = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_out_data", out_data, 0);
        chk("async_out_mode", out_mode, 0);
        chk("async_in_ready", in_ready, 1);
        sb_q.delete();
        m_hv = 1'b0;
        base = cap_q.size();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("no_stale_valid", out_valid, 0);
        send_beat(1'b0, 8'h0B);
        drain();
        chk("post_rst_count", cap_q.size(), base + 1);
        if (cap_q.size() >= base + 1) chk("post_rst_data", cap_q[base].d8, 8'h0D);

        // Step checking sequence
        do_reset();
        out_ready = 1'b1;
        base = cap_q.size();
        for (int i = 0; i < 6; i++) send_beat(stp[i].mode, stp[i].din);
        drain();
        chk("step_count", cap_q.size(), base + 6);
        if (cap_q.size() >= base + 6)
            for (int i = 0; i < 6; i++) chk("step_seq", cap_q[base + i].err, stp[i].err);

        // Alternating then random modes under random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 100; i++) send_beat(1'(i % 2), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) step();
            send_beat(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        rand_rdy = 1'b0;
        step();
        out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
